// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative write-back cache with tree-PLRU replacement and hit/miss counters
module cache_nway #(
  parameter int WAYS = 2,
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);
  localparam int S = $clog2(SETS);
  localparam int LW = $clog2(WAYS);
  localparam int TW = 27 - S;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  state_t state;
  logic [255:0] data [SETS][WAYS];
  logic [TW-1:0] tags [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0] valid, dirty;
  logic [SETS-1:0][WAYS-2:0] plru;
  logic [WAYS-1:0] match;
  logic [LW-1:0] hit_way, inv_way, plru_way, victim, victim_now;
  logic hit, missed, req, miss;
  logic [S-1:0] idx;
  logic [TW-1:0] tag;
  logic [2:0] word;
  logic unused;
  assign unused = ^mem_address[1:0];
  assign idx = mem_address[4+S:5];
  assign tag = mem_address[31:5+S];
  assign word = mem_address[4:2];
  function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] p, input logic [LW-1:0] a);
    logic [WAYS-2:0] r;
    r = p;
    for (int l = 0; l < LW; l++) r[LW'((1 << l) - 1 + (int'(a) >> (LW - l)))] = ~a[LW'(LW - 1 - l)];
    return r;
  endfunction
  always_comb begin
    int n;
    logic b;
    match = '0;
    hit_way = '0;
    inv_way = '0;
    plru_way = '0;
    n = 0;
    b = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match[LW'(w)] = valid[idx][LW'(w)] && tags[idx][LW'(w)] == tag;
      if (match[LW'(w)]) hit_way = LW'(w);
      if (!valid[idx][LW'(w)]) inv_way = LW'(w);
    end
    for (int l = 0; l < LW; l++) begin
      b = plru[idx][LW'(n)];
      plru_way[LW'(LW - 1 - l)] = b;
      n = 2 * n + 1 + int'(b);
    end
  end
  assign hit = $onehot(match);
  assign req = mem_read | mem_write;
  assign mem_resp = state == IDLE && req && hit;
  assign miss = state == IDLE && req && !hit;
  assign victim_now = &valid[idx] ? plru_way : inv_way;
  assign mem_rdata = data[idx][hit_way][{word, 5'b0} +: 32];
  assign pmem_read = state == FILL;
  assign pmem_write = state == WRITEBACK;
  assign pmem_address = state == WRITEBACK ? {tags[idx][victim], idx, 5'b0} : {mem_address[31:5], 5'b0};
  assign pmem_wdata = data[idx][victim];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      plru <= '0;
      hit_count <= '0;
      miss_count <= '0;
      missed <= 1'b0;
      victim <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_resp) begin
            plru[idx] <= touch(plru[idx], hit_way);
            if (mem_write) dirty[idx][hit_way] <= 1'b1;
            if (!missed) hit_count <= hit_count + 32'd1;
            missed <= 1'b0;
          end else if (miss) begin
            miss_count <= miss_count + 32'd1;
            missed <= 1'b1;
            victim <= victim_now;
            state <= dirty[idx][victim_now] ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: if (pmem_resp) begin
          dirty[idx][victim] <= 1'b0;
          state <= FILL;
        end
        FILL: if (pmem_resp) begin
          valid[idx][victim] <= 1'b1;
          dirty[idx][victim] <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Tag and data arrays are plain storage and are intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && state == FILL && pmem_resp) begin
      data[idx][victim] <= pmem_rdata;
      tags[idx][victim] <= tag;
    end else if (!rst && mem_resp && mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[2'(b)]) data[idx][hit_way][{word, 2'(b), 3'b0} +: 8] <= mem_wdata[{2'(b), 3'b0} +: 8];
    end
  end
endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: scoreboard bench for cache_nway, 2-way and 4-way instances sharing one stimulus port
module tb_cache_nway;
  logic clk = 1'b0;
  logic rst, sel, rd, wr, presp;
  logic [31:0] addr, wd;
  logic [3:0] be;
  logic [31:0] rdata0, rdata1, paddr0, paddr1, hc0, hc1, mc0, mc1;
  logic resp0, resp1, pr0, pr1, pw0, pw1;
  logic [255:0] pwd0, pwd1, prdata;
  logic [31:0] rdata, paddr;
  logic resp, pr, pw;
  logic [255:0] pwd;
  int pcnt;
  int total = 0, bad = 0;
  typedef struct {logic miss; logic chk; logic [31:0] d;} exp_t;
  typedef struct {logic wr; logic [31:0] a; logic chk; logic [255:0] w;} pexp_t;
  exp_t rq[$];
  pexp_t pq[$];
  always #5 clk = ~clk;
  cache_nway #(.WAYS(2), .SETS(8)) dut (
    .clk(clk), .rst(rst), .mem_address(addr), .mem_read(rd & ~sel), .mem_write(wr & ~sel),
    .mem_byte_enable(be), .mem_wdata(wd), .mem_rdata(rdata0), .mem_resp(resp0),
    .pmem_address(paddr0), .pmem_read(pr0), .pmem_write(pw0), .pmem_wdata(pwd0),
    .pmem_rdata(prdata), .pmem_resp(presp & ~sel), .hit_count(hc0), .miss_count(mc0));
  cache_nway #(.WAYS(4), .SETS(8)) dut4 (
    .clk(clk), .rst(rst), .mem_address(addr), .mem_read(rd & sel), .mem_write(wr & sel),
    .mem_byte_enable(be), .mem_wdata(wd), .mem_rdata(rdata1), .mem_resp(resp1),
    .pmem_address(paddr1), .pmem_read(pr1), .pmem_write(pw1), .pmem_wdata(pwd1),
    .pmem_rdata(prdata), .pmem_resp(presp & sel), .hit_count(hc1), .miss_count(mc1));
  assign rdata = sel ? rdata1 : rdata0;
  assign resp = sel ? resp1 : resp0;
  assign paddr = sel ? paddr1 : paddr0;
  assign pr = sel ? pr1 : pr0;
  assign pw = sel ? pw1 : pw0;
  assign pwd = sel ? pwd1 : pwd0;
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = {16'hCAFE, a[11:8], 9'b0, 3'(k)};
    return r;
  endfunction
  assign prdata = line_of(paddr);
  // Physical memory answers every request after a fixed three-cycle wait.
  always @(posedge clk) begin
    if (rst) begin
      presp <= 1'b0;
      pcnt <= 0;
    end else if (presp) presp <= 1'b0;
    else if (pr | pw) begin
      if (pcnt == 2) begin
        presp <= 1'b1;
        pcnt <= 0;
      end else pcnt <= pcnt + 1;
    end
  end
  initial begin
    exp_t e;
    pexp_t p;
    logic [1:0] prev_p;
    logic prev_r;
    prev_p = 2'b00;
    prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (resp) begin
          total++;
          if (rq.size() == 0) begin
            bad++;
            $display("FAIL resp_unexpected addr=%h", addr);
          end else begin
            e = rq.pop_front();
            if (e.chk && rdata !== e.d) begin
              bad++;
              $display("FAIL rdata addr=%h got=%h exp=%h", addr, rdata, e.d);
            end
            if (prev_r !== e.miss) begin
              bad++;
              $display("FAIL resp_timing addr=%h pmem_resp_prev=%0d exp=%0d", addr, prev_r, e.miss);
            end
          end
        end
        if ({pw, pr} != 2'b00 && {pw, pr} != prev_p) begin
          total++;
          if (pq.size() == 0) begin
            bad++;
            $display("FAIL pmem_unexpected wr=%0d addr=%h", pw, paddr);
          end else begin
            p = pq.pop_front();
            if (pw !== p.wr || paddr !== p.a || (p.chk && pwd !== p.w)) begin
              bad++;
              $display("FAIL pmem wr=%0d addr=%h wdata=%h exp wr=%0d addr=%h wdata=%h", pw, paddr, pwd, p.wr, p.a, p.w);
            end
          end
        end
        if (pr && pw) begin
          total++;
          bad++;
          $display("FAIL pmem_both got read=1 write=1 exp not both");
        end
      end
      prev_r = presp;
      prev_p = {pw, pr};
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic pexp(input logic w, input logic [31:0] a, input logic c, input logic [255:0] d);
    pq.push_back('{w, a, c, d});
  endtask
  task automatic req(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d,
                     input logic m, input logic c, input logic [31:0] x);
    int n;
    rq.push_back('{m, c, x});
    @(posedge clk);
    #1 addr = a; wr = w; rd = !w; be = b; wd = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp && n < 100);
    if (!resp) begin
      total++;
      bad++;
      $display("FAIL req_timeout addr=%h got no mem_resp exp mem_resp", a);
    end
    @(posedge clk);
    #1 rd = 1'b0; wr = 1'b0;
  endtask
  task automatic rdq(input logic [31:0] a, input logic m, input logic [31:0] x);
    req(a, 1'b0, 4'h0, 32'h0, m, 1'b1, x);
  endtask
  initial begin
    logic [255:0] mod;
    int n;
    rst = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; be = 4'h0; wd = '0; addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_resp", {31'b0, resp0}, 32'h0);
    chk("reset_pmem", {30'b0, pr0, pw0}, 32'h0);
    chk("reset_hits", hc0, 32'h0);
    chk("reset_miss", mc0, 32'h0);
    pexp(1'b0, 32'h40, 1'b0, '0);
    rdq(32'h44, 1'b1, 32'hCAFE_0001);
    chk("first_miss_cnt", mc0, 32'd1);
    chk("first_hit_cnt", hc0, 32'd0);
    rdq(32'h48, 1'b0, 32'hCAFE_0002);
    chk("hit_cnt_1", hc0, 32'd1);
    req(32'h44, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    rdq(32'h44, 1'b0, 32'hCAFE_BEEF);
    chk("hit_cnt_3", hc0, 32'd3);
    rdq(32'h40, 1'b0, 32'hCAFE_0000);
    pexp(1'b0, 32'h140, 1'b0, '0);
    rdq(32'h140, 1'b1, 32'hCAFE_1000);
    rdq(32'h40, 1'b0, 32'hCAFE_0000);
    pexp(1'b0, 32'h240, 1'b0, '0);
    rdq(32'h240, 1'b1, 32'hCAFE_2000);
    chk("miss_cnt_3", mc0, 32'd3);
    mod = line_of(32'h40);
    mod[63:32] = 32'hCAFE_BEEF;
    pexp(1'b1, 32'h40, 1'b1, mod);
    pexp(1'b0, 32'h340, 1'b0, '0);
    rdq(32'h344, 1'b1, 32'hCAFE_3001);
    pexp(1'b0, 32'h140, 1'b0, '0);
    rdq(32'h140, 1'b1, 32'hCAFE_1000);
    req(32'h144, 1'b1, 4'b0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    rdq(32'h340, 1'b0, 32'hCAFE_3000);
    pexp(1'b1, 32'h140, 1'b1, line_of(32'h140));
    pexp(1'b0, 32'h240, 1'b0, '0);
    rdq(32'h248, 1'b1, 32'hCAFE_2002);
    chk("miss_cnt_6", mc0, 32'd6);
    chk("hit_cnt_7", hc0, 32'd7);
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pexp(1'b0, 32'h40 + 32'(i) * 32'h100, 1'b0, '0);
      req(32'h40 + 32'(i) * 32'h100, 1'b1, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0);
    end
    chk("w4_fill_hits", hc1, 32'd0);
    rdq(32'h40, 1'b0, 32'hCAFE_0000);
    rdq(32'h240, 1'b0, 32'hCAFE_2000);
    pexp(1'b1, 32'h140, 1'b1, line_of(32'h140));
    pexp(1'b0, 32'h440, 1'b0, '0);
    rdq(32'h44C, 1'b1, 32'hCAFE_4003);
    rdq(32'h40, 1'b0, 32'hCAFE_0000);
    rdq(32'h240, 1'b0, 32'hCAFE_2000);
    rdq(32'h340, 1'b0, 32'hCAFE_3000);
    chk("w4_hits", hc1, 32'd5);
    chk("w4_miss", mc1, 32'd5);
    sel = 1'b0;
    pexp(1'b0, 32'h540, 1'b0, '0);
    @(posedge clk);
    #1 addr = 32'h540; rd = 1'b1; wr = 1'b0;
    n = 0;
    while (!pr && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midfill_pmem_read", {31'b0, pr}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b1; rd = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pmem_read", {31'b0, pr0}, 32'h0);
    chk("rst_pmem_write", {31'b0, pw0}, 32'h0);
    chk("rst_hits", hc0, 32'h0);
    chk("rst_miss", mc0, 32'h0);
    pexp(1'b0, 32'h40, 1'b0, '0);
    rdq(32'h48, 1'b1, 32'hCAFE_0002);
    chk("post_rst_miss", mc0, 32'd1);
    chk("post_rst_hits", hc0, 32'd0);
    repeat (2) @(negedge clk);
    chk("resp_queue_empty", 32'(rq.size()), 32'd0);
    chk("pmem_queue_empty", 32'(pq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
